// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program counter and instruction-fetch sequencer.
// Holds the PC, keeps at most one instruction-memory request in flight,
// hands each fetched word plus its address to decode, and steers the PC on
// trap / jump / branch redirects. A redirect that lands while a request is
// still in flight parks the FSM in KILL until the stale response drains.
module pc_fetch_ctrl #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h00000000,
  parameter logic [WIDTH-1:0] TRAP_VEC = 32'h00000080,
  parameter int               STEP     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jmp,
  input  logic [WIDTH-1:0] jmp_target,
  input  logic             trap,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic             instr_valid,
  output logic [31:0]      instr,
  output logic [WIDTH-1:0] instr_pc,
  output logic [WIDTH-1:0] pc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    KILL  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] ALIGN_MASK = {{(WIDTH-2){1'b1}}, 2'b00};
  localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] pc_n;
  logic [WIDTH-1:0] addr_n;
  logic [WIDTH-1:0] ipc_n;
  logic [31:0]      instr_n;
  logic             valid_n;

  logic             redirect;
  logic [WIDTH-1:0] target_raw;
  logic [WIDTH-1:0] target;

  // Resolve the redirect source by priority (trap, then jump, then branch) and word-align it.
  always_comb begin
    redirect   = trap | jmp | br_taken;
    target_raw = br_target;
    if (trap) begin
      target_raw = TRAP_VEC;
    end else if (jmp) begin
      target_raw = jmp_target;
    end
    target = target_raw & ALIGN_MASK;
  end

  // Next-state and next-register values; everything holds unless a state says otherwise.
  always_comb begin
    state_n  = state;
    pc_n     = pc;
    addr_n   = imem_addr;
    ipc_n    = instr_pc;
    instr_n  = instr;
    valid_n  = instr_valid;
    imem_req = 1'b0;

    case (state)
      IDLE: begin
        addr_n  = pc;
        state_n = FETCH;
      end

      FETCH: begin
        imem_req = 1'b1;
        if (redirect) begin
          pc_n = target;
          if (imem_ack) begin
            addr_n = target;
          end else begin
            state_n = KILL;
          end
        end else if (imem_ack) begin
          instr_n = imem_rdata;
          ipc_n   = imem_addr;
          valid_n = 1'b1;
          pc_n    = pc + STEP_W;
          state_n = HOLD;
        end
      end

      HOLD: begin
        if (redirect) begin
          valid_n = 1'b0;
          pc_n    = target;
          addr_n  = target;
          state_n = FETCH;
        end else if (!stall) begin
          valid_n = 1'b0;
          addr_n  = pc;
          state_n = FETCH;
        end
      end

      KILL: begin
        imem_req = 1'b1;
        if (redirect) begin
          pc_n = target;
          if (imem_ack) begin
            addr_n  = target;
            state_n = FETCH;
          end
        end else if (imem_ack) begin
          addr_n  = pc;
          state_n = FETCH;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      imem_addr   <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= 32'h0;
      instr_pc    <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      imem_addr   <= addr_n;
      instr_valid <= valid_n;
      instr       <= instr_n;
      instr_pc    <= ipc_n;
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Testbench for pc_fetch_ctrl: directed scenarios plus a randomized run
// checked against a transaction-level model of the fetch stream.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] K       = 32'hA5A5A5A5;
  localparam logic [31:0] TRAPV   = 32'h00000080;
  localparam logic [31:0] WRAP_PC = 32'hFFFFFFFC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, br_taken, jmp, trap, imem_ack;
  logic [31:0] br_target, jmp_target, imem_rdata;
  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, instr, instr_pc, pc;

  logic        rst_w, imem_ack_w;
  logic [31:0] imem_rdata_w;
  logic        imem_req_w, instr_valid_w;
  logic [31:0] imem_addr_w, instr_w, instr_pc_w, pc_w;

  int errors = 0;
  int checks = 0;

  pc_fetch_ctrl dut (
    .clk(clk), .rst(rst), .stall(stall),
    .br_taken(br_taken), .br_target(br_target),
    .jmp(jmp), .jmp_target(jmp_target), .trap(trap),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .pc(pc)
  );

  pc_fetch_ctrl #(.RESET_PC(32'hFFFFFFFC)) dutw (
    .clk(clk), .rst(rst_w), .stall(stall),
    .br_taken(br_taken), .br_target(br_target),
    .jmp(jmp), .jmp_target(jmp_target), .trap(trap),
    .imem_req(imem_req_w), .imem_addr(imem_addr_w),
    .imem_ack(imem_ack_w), .imem_rdata(imem_rdata_w),
    .instr_valid(instr_valid_w), .instr(instr_w), .instr_pc(instr_pc_w), .pc(pc_w)
  );

  // One clock: inputs change and outputs are sampled on the falling edge.
  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs;
    stall = 0; br_taken = 0; br_target = 0; jmp = 0; jmp_target = 0;
    trap = 0; imem_ack = 0; imem_rdata = 0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst = 0;
    step();
    step();
  endtask

  // Memory answers d cycles after the current (first request) cycle.
  task automatic ack_after(input int d, input logic [31:0] a);
    repeat (d) step();
    imem_ack = 1; imem_rdata = a ^ K;
    step();
    imem_ack = 0; imem_rdata = 0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_req: got %b want 0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid: got %b want 0", instr_valid); end
    checks++; if (instr !== 32'h0) begin errors++; $display("[TB] FAIL rst_instr: got %h want 0", instr); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("[TB] FAIL rst_instr_pc: got %h want 0", instr_pc); end
    checks++; if (pc !== 32'h0) begin errors++; $display("[TB] FAIL rst_pc: got %h want 0", pc); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL rst_addr: got %h want 0", imem_addr); end
  endtask

  task automatic test_sequential;
    logic [31:0] a;
    rst = 1;
    step();
    for (int i = 0; i < 3; i++) begin
      a = 32'(i * 4);
      checks++; if (imem_req !== 1'b1 || imem_addr !== a) begin errors++; $display("[TB] FAIL seq_req%0d: got req=%b addr=%h want req=1 addr=%h", i, imem_req, imem_addr, a); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL seq_pulse%0d: got valid=%b want 0", i, instr_valid); end
      ack_after(1, a);
      checks++; if (instr_valid !== 1'b1 || instr_pc !== a || instr !== (a ^ K)) begin errors++; $display("[TB] FAIL seq_instr%0d: got v=%b pc=%h i=%h want v=1 pc=%h i=%h", i, instr_valid, instr_pc, instr, a, a ^ K); end
      checks++; if (pc !== a + 32'd4 || imem_req !== 1'b0) begin errors++; $display("[TB] FAIL seq_pc%0d: got pc=%h req=%b want pc=%h req=0", i, pc, imem_req, a + 32'd4); end
      if (i < 2) step();
    end
  endtask

  task automatic test_stall;
    do_reset();
    rst = 1;
    step();
    ack_after(1, 32'h0);
    step();
    stall = 1;
    ack_after(1, 32'h4);
    for (int i = 0; i < 3; i++) begin
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h4 || instr !== (32'h4 ^ K) || imem_req !== 1'b0) begin errors++; $display("[TB] FAIL stall_hold%0d: got v=%b pc=%h i=%h req=%b want v=1 pc=4 i=%h req=0", i, instr_valid, instr_pc, instr, imem_req, 32'h4 ^ K); end
      step();
    end
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_last: got v=%b want 1", instr_valid); end
    stall = 0;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8 || instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_release: got req=%b addr=%h v=%b want req=1 addr=8 v=0", imem_req, imem_addr, instr_valid); end
  endtask

  task automatic test_jump;
    ack_after(1, 32'h8);
    stall = 1; jmp = 1; jmp_target = 32'h100;
    step();
    jmp = 0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL jmp_drop: got v=%b want 0", instr_valid); end
    checks++; if (imem_addr !== 32'h100 || imem_req !== 1'b1 || pc !== 32'h100) begin errors++; $display("[TB] FAIL jmp_addr: got addr=%h req=%b pc=%h want addr=100 req=1 pc=100", imem_addr, imem_req, pc); end
    ack_after(1, 32'h100);
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== (32'h100 ^ K)) begin errors++; $display("[TB] FAIL jmp_fetch: got v=%b pc=%h i=%h want v=1 pc=100", instr_valid, instr_pc, instr); end
    stall = 0;
  endtask

  task automatic test_kill;
    do_reset();
    rst = 1;
    step();
    ack_after(1, 32'h0);
    step();
    ack_after(1, 32'h4);
    step();
    br_taken = 1; br_target = 32'h40;
    step();
    br_taken = 0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8 || pc !== 32'h40) begin errors++; $display("[TB] FAIL kill_enter: got req=%b addr=%h pc=%h want req=1 addr=8 pc=40", imem_req, imem_addr, pc); end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8 || instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL kill_wait%0d: got req=%b addr=%h v=%b want req=1 addr=8 v=0", i, imem_req, imem_addr, instr_valid); end
    end
    imem_ack = 1; imem_rdata = 32'h8 ^ K;
    step();
    imem_ack = 0;
    checks++; if (instr_valid !== 1'b0 || imem_addr !== 32'h40 || imem_req !== 1'b1) begin errors++; $display("[TB] FAIL kill_discard: got v=%b addr=%h req=%b want v=0 addr=40 req=1", instr_valid, imem_addr, imem_req); end
    ack_after(1, 32'h40);
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h40) begin errors++; $display("[TB] FAIL kill_refetch: got v=%b pc=%h want v=1 pc=40", instr_valid, instr_pc); end
  endtask

  task automatic test_priority;
    trap = 1; jmp = 1; jmp_target = 32'h200; br_taken = 1; br_target = 32'h300;
    step();
    clear_inputs();
    checks++; if (pc !== TRAPV || imem_addr !== TRAPV) begin errors++; $display("[TB] FAIL prio_trap: got pc=%h addr=%h want 80", pc, imem_addr); end
    ack_after(1, TRAPV);
    br_taken = 1; br_target = 32'h43;
    step();
    clear_inputs();
    checks++; if (pc !== 32'h40 || imem_addr !== 32'h40) begin errors++; $display("[TB] FAIL prio_align: got pc=%h addr=%h want 40", pc, imem_addr); end
    jmp = 1; jmp_target = 32'h203; br_taken = 1; br_target = 32'h300;
    step();
    clear_inputs();
    checks++; if (pc !== 32'h200 || imem_addr !== 32'h40) begin errors++; $display("[TB] FAIL prio_jmp: got pc=%h addr=%h want pc=200 addr=40", pc, imem_addr); end
  endtask

  task automatic test_wrap;
    rst = 0;
    clear_inputs();
    rst_w = 0; imem_ack_w = 0; imem_rdata_w = 0;
    step();
    step();
    rst_w = 1;
    step();
    checks++; if (imem_req_w !== 1'b1 || imem_addr_w !== WRAP_PC) begin errors++; $display("[TB] FAIL wrap_first: got req=%b addr=%h want req=1 addr=%h", imem_req_w, imem_addr_w, WRAP_PC); end
    step();
    imem_ack_w = 1; imem_rdata_w = WRAP_PC ^ K;
    step();
    imem_ack_w = 0;
    checks++; if (instr_valid_w !== 1'b1 || instr_pc_w !== WRAP_PC || pc_w !== 32'h0) begin errors++; $display("[TB] FAIL wrap_pc: got v=%b ipc=%h pc=%h want v=1 ipc=%h pc=0", instr_valid_w, instr_pc_w, pc_w, WRAP_PC); end
    step();
    checks++; if (imem_addr_w !== 32'h0 || imem_req_w !== 1'b1) begin errors++; $display("[TB] FAIL wrap_second: got addr=%h req=%b want addr=0 req=1", imem_addr_w, imem_req_w); end
    br_taken = 1; br_target = 32'h40;
    step();
    br_taken = 0;
    checks++; if (pc_w !== 32'h40 || imem_addr_w !== 32'h0) begin errors++; $display("[TB] FAIL wrap_kill: got pc=%h addr=%h want pc=40 addr=0", pc_w, imem_addr_w); end
    rst_w = 0;
    step();
    checks++; if (imem_req_w !== 1'b0 || instr_valid_w !== 1'b0 || instr_w !== 32'h0 || instr_pc_w !== 32'h0 || pc_w !== WRAP_PC || imem_addr_w !== WRAP_PC) begin errors++; $display("[TB] FAIL wrap_reset: got req=%b v=%b i=%h ipc=%h pc=%h addr=%h", imem_req_w, instr_valid_w, instr_w, instr_pc_w, pc_w, imem_addr_w); end
    rst_w = 1; imem_ack_w = 1; imem_rdata_w = 32'hDEADBEEF;
    step();
    imem_ack_w = 0;
    checks++; if (imem_req_w !== 1'b1 || imem_addr_w !== WRAP_PC || instr_valid_w !== 1'b0 || pc_w !== WRAP_PC) begin errors++; $display("[TB] FAIL wrap_postrst: got req=%b addr=%h v=%b pc=%h", imem_req_w, imem_addr_w, instr_valid_w, pc_w); end
    step();
    checks++; if (imem_req_w !== 1'b1 || instr_valid_w !== 1'b0) begin errors++; $display("[TB] FAIL wrap_ackign: got req=%b v=%b want req=1 v=0", imem_req_w, instr_valid_w); end
    imem_ack_w = 1; imem_rdata_w = WRAP_PC ^ K;
    step();
    imem_ack_w = 0;
    checks++; if (instr_valid_w !== 1'b1 || instr_pc_w !== WRAP_PC || instr_w !== (WRAP_PC ^ K)) begin errors++; $display("[TB] FAIL wrap_refetch: got v=%b ipc=%h i=%h", instr_valid_w, instr_pc_w, instr_w); end
    rst_w = 0;
  endtask

  // Random run: the model tracks the expected fetch address, the in-flight
  // request (and whether a redirect has doomed it) and the held instruction.
  task automatic test_random;
    logic [31:0] exp_fetch, exp_instr, exp_ipc, mem_addr, tgt;
    logic        exp_valid, busy, killed, idle, redir, real_ack, nvalid;
    int          wait_c, r;
    do_reset();
    rst = 1;
    exp_fetch = 32'h0; exp_instr = 0; exp_ipc = 0; mem_addr = 0;
    exp_valid = 0; busy = 0; killed = 0; idle = 1; wait_c = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      checks++; if (instr_valid !== exp_valid) begin errors++; $display("[TB] FAIL rnd_valid@%0d: got %b want %b", cyc, instr_valid, exp_valid); end
      if (exp_valid) begin
        checks++; if (instr !== exp_instr || instr_pc !== exp_ipc) begin errors++; $display("[TB] FAIL rnd_instr@%0d: got i=%h pc=%h want i=%h pc=%h", cyc, instr, instr_pc, exp_instr, exp_ipc); end
      end
      checks++; if (pc !== exp_fetch) begin errors++; $display("[TB] FAIL rnd_pc@%0d: got %h want %h", cyc, pc, exp_fetch); end
      checks++; if (imem_req !== (!idle && !exp_valid)) begin errors++; $display("[TB] FAIL rnd_req@%0d: got %b want %b", cyc, imem_req, !idle && !exp_valid); end
      if (imem_req === 1'b1) begin
        if (busy) begin
          checks++; if (imem_addr !== mem_addr) begin errors++; $display("[TB] FAIL rnd_addr_stable@%0d: got %h want %h", cyc, imem_addr, mem_addr); end
        end else begin
          checks++; if (imem_addr !== exp_fetch) begin errors++; $display("[TB] FAIL rnd_addr_new@%0d: got %h want %h", cyc, imem_addr, exp_fetch); end
          busy = 1; killed = 0; mem_addr = exp_fetch; wait_c = $urandom_range(1, 3);
        end
      end

      stall = ($urandom_range(0, 1) == 1);
      br_target = $urandom; jmp_target = $urandom;
      trap = 0; jmp = 0; br_taken = 0;
      if (!idle && $urandom_range(0, 5) == 0) begin
        r = $urandom_range(1, 7);
        trap = r[2]; jmp = r[1]; br_taken = r[0];
      end
      imem_ack = 0; imem_rdata = $urandom;
      if (busy) begin
        if (wait_c == 0) begin
          imem_ack = 1; imem_rdata = mem_addr ^ K;
        end else begin
          wait_c--;
        end
      end else if (!idle && $urandom_range(0, 3) == 0) begin
        imem_ack = 1;
      end

      redir = !idle && (trap || jmp || br_taken);
      tgt = trap ? TRAPV : (jmp ? jmp_target : br_target);
      tgt[1:0] = 2'b00;
      real_ack = busy && imem_ack;
      nvalid = exp_valid && !redir && stall;
      if (real_ack) begin
        busy = 0;
        if (!killed && !redir) begin
          nvalid = 1; exp_instr = mem_addr ^ K; exp_ipc = mem_addr; exp_fetch = mem_addr + 32'd4;
        end
      end else if (busy && redir) begin
        killed = 1;
      end
      if (redir) exp_fetch = tgt;
      exp_valid = nvalid;
      idle = 0;
      step();
    end
    clear_inputs();
  endtask

  initial begin
    rst = 0; rst_w = 0; imem_ack_w = 0; imem_rdata_w = 0;
    clear_inputs();
    test_reset();
    test_sequential();
    test_stall();
    test_jump();
    test_kill();
    test_priority();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Sequences the program counter and instruction-memory fetch for the processor core. It holds the PC, issues one instruction-memory request at a time, and presents each fetched instruction and its PC to decode. It also applies redirects from branch, jump and trap. It sits between the PC datapath and the instruction memory and replaces free-running PC increment with a handshaked fetch.

Parameters:
WIDTH, 32, PC / address width in bits
RESET_PC, 32'h00000000, first fetch address after reset
TRAP_VEC, 32'h00000080, redirect target on trap
STEP, 4, PC increment per instruction in bytes

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
stall  in  1  decode not ready; held instruction is not consumed
br_taken  in  1  branch redirect request
br_target  in  WIDTH  branch target
jmp  in  1  jump redirect request
jmp_target  in  WIDTH  jump target
trap  in  1  trap redirect request (to TRAP_VEC)
imem_req  out  1  instruction memory request
imem_addr  out  WIDTH  request address, registered
imem_ack  in  1  memory response valid, one-cycle pulse
imem_rdata  in  32  instruction word, valid with imem_ack
instr_valid  out  1  instr/instr_pc valid
instr  out  32  fetched instruction
instr_pc  out  WIDTH  address of instr
pc  out  WIDTH  next fetch address

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE, pc=imem_addr=RESET_PC.
  - imem_req=0, instr_valid=0, instr=0, instr_pc=0.
  - Any outstanding request is abandoned; instruction memory is reset by the same rst.
- States:
  - IDLE: imem_req=0; imem_ack ignored. Next state FETCH, with imem_addr<=pc.
  - FETCH: imem_req=1, imem_addr=pc.
    - On imem_ack: instr<=imem_rdata, instr_pc<=imem_addr, instr_valid<=1, pc<=pc+STEP; go HOLD.
  - HOLD: imem_req=0; instr, instr_pc and instr_valid are held stable.
    - Cycle with stall=0: instr consumed; instr_valid<=0; imem_addr<=pc; go FETCH.
  - KILL: imem_req=1, imem_addr = address of the outstanding request, unchanged.
    - On imem_ack: data discarded, instr_valid stays 0; imem_addr<=pc; go FETCH.
- Handshake:
  - At most one request outstanding.
  - imem_req and imem_addr stay stable until imem_ack; a request is never withdrawn.
  - Ack latency is arbitrary, ≥1 cycle after imem_req first asserted.
  - Latency: ack in cycle N gives instr_valid=1 in cycle N+1.
- Redirect:
  - Redirect = trap|jmp|br_taken. Priority: trap > jmp > br_taken.
  - target = TRAP_VEC / jmp_target / br_target, with bits [1:0] forced to 0.
  - Accepted in every state except IDLE; pc<=target.
  - In HOLD: instr_valid<=0 (held instruction dropped), imem_addr<=target, go FETCH. stall is ignored.
  - In FETCH with imem_ack in the same cycle: returned data discarded, imem_addr<=target, stay FETCH.
  - In FETCH without imem_ack: go KILL.
  - In KILL: pc updated; if imem_ack in the same cycle go FETCH with imem_addr<=target, else stay KILL.
- Arithmetic: pc+STEP wraps modulo 2^WIDTH.
- stall is ignored outside HOLD.
- imem_ack outside FETCH/KILL is ignored.

Test Plan:
1. Release rst, memory acks 1 cycle after each request with rdata=addr^32'hA5A5A5A5, stall=0 -> imem_addr sequence 0x0,0x4,0x8; instr_pc matches; each instr_valid pulse is 1 cycle; pc=0xC after third fetch.
2. stall=1 for 3 cycles while in HOLD with instr_pc=0x4 -> instr, instr_pc and instr_valid stable for 3 cycles; imem_req=0; next request to 0x8 the cycle after stall drops.
3. jmp=1, jmp_target=0x100 in HOLD with stall=1 -> instr_valid=0 next cycle; next imem_addr=0x100; following fetch instr_pc=0x100.
4. br_taken, br_target=0x40 while request to 0x8 outstanding, ack delayed 3 cycles -> imem_addr stays 0x8 until ack; data discarded with instr_valid=0; then request to 0x40.
5. trap=1, jmp=1 (0x200), br_taken=1 (0x300) in same cycle -> pc=0x80. Separately br_target=0x43 -> pc=0x40.
6. RESET_PC=32'hFFFFFFFC -> first fetch 0xFFFFFFFC, second fetch 0x0. Then drive rst=0 during KILL with imem_ack=1 in the first post-reset cycle -> outputs at reset values, ack ignored, first request to RESET_PC.
